// File: rtl/seg_pkg.sv
// Shared constants and helpers for the four-digit seven-segment scan driver.
package seg_pkg;

   localparam int NDIG = 4;
   localparam logic [3:0] ANODE_OFF = 4'b1111;

   typedef logic [1:0] dig_idx_t;

   function automatic logic [3:0] anode_from_idx(input dig_idx_t idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/seg_scan_tick_gen.sv
// Refresh prescaler: raises tick for one cycle every REFRESH_DIV clocks.
module tick_gen #(
   parameter int REFRESH_DIV = 50000,
   parameter int CNT_W       = 16
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      tick  = (cnt_q == LAST);
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed display scanner with frame-synchronous double
// buffering of the displayed value and optional leading-zero blanking.
module seg_scan
   import seg_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int CNT_W       = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] value,
   input  logic        load,
   input  logic        blank_lz,
   output logic [3:0]  x,
   output logic [3:0]  anode_L,
   output logic        commit
);

   logic        tick;
   logic        frame_wrap;
   logic        upper_nz;
   logic        blanked;

   dig_idx_t    idx_q;
   dig_idx_t    idx_d;
   logic [15:0] disp_q;
   logic [15:0] disp_d;
   logic [15:0] pend_q;
   logic [15:0] pend_d;
   logic        pend_v_q;
   logic        pend_v_d;
   logic        commit_q;
   logic        commit_d;

   tick_gen #(
      .REFRESH_DIV(REFRESH_DIV),
      .CNT_W      (CNT_W)
   ) u_tick_gen (
      .clk (clk),
      .rst (rst),
      .tick(tick)
   );

   // A load landing on the commit edge still commits the old pending value;
   // the new one stays pending for the following frame.
   always_comb begin
      frame_wrap = tick && (idx_q == dig_idx_t'(NDIG - 1));
      idx_d      = tick ? idx_q + dig_idx_t'(1) : idx_q;
      commit_d   = frame_wrap && pend_v_q;
      disp_d     = commit_d ? pend_q : disp_q;
      pend_d     = load ? value : pend_q;
      pend_v_d   = load || (pend_v_q && !commit_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q    <= '0;
         disp_q   <= '0;
         pend_q   <= '0;
         pend_v_q <= 1'b0;
         commit_q <= 1'b0;
      end else begin
         idx_q    <= idx_d;
         disp_q   <= disp_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         commit_q <= commit_d;
      end
   end

   // Digit 0 is never blanked, so a zero value still shows a single "0".
   always_comb begin
      upper_nz = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if ((i >= int'(idx_q)) && (disp_q[4*i +: 4] != 4'h0)) begin
            upper_nz = 1'b1;
         end
      end
      blanked = blank_lz && (idx_q != '0) && !upper_nz;
      anode_L = blanked ? ANODE_OFF : anode_from_idx(idx_q);
   end

   assign x      = disp_q[{idx_q, 2'b00} +: 4];
   assign commit = commit_q;

endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed scan driver for the four-digit seven-segment display. Holds a 16-bit hex value, cycles through the four digits at a programmable refresh rate, and presents one nibble at a time to the downstream single-digit segment decoder (`x[3:0]`) together with the matching active-low anode select. New values are double-buffered and committed only at a frame boundary so a digit never tears mid-frame; optional leading-zero blanking.

## Interface
Parameters:
- `REFRESH_DIV`, 50000, clock cycles each digit stays lit (≥2)
- `CNT_W`, 16, prescaler counter width; must satisfy 2^CNT_W ≥ REFRESH_DIV

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `value`  in  16  hex value, digit 0 = `value[3:0]` (rightmost)
- `load`  in  1  single-cycle strobe; captures `value` into pending buffer
- `blank_lz`  in  1  1: blank leading zero digits (digit 0 never blanked)
- `x`  out  4  nibble of current digit, to segment decoder
- `anode_L`  out  4  active-low digit enable, one-hot-low or all-ones
- `commit`  out  1  one-cycle pulse when pending value becomes displayed

## Operation
- Registers: `cnt` (CNT_W), `idx` (2), `disp` (16), `pend` (16), `pend_v` (1), `commit` (1).
- Prescaler: `cnt` counts 0..REFRESH_DIV-1, wraps to 0; `tick` = (`cnt` == REFRESH_DIV-1), internal, combinational.
- On `tick`: `idx` ← `idx`+1 mod 4 (3 wraps to 0). No other `idx` change.
- `x` = `disp[4*idx+3 : 4*idx]`; combinational from `idx`/`disp` only (no input-to-output path).
- `anode_L` = ~(1 << `idx`), unless blanked → 4'b1111.
- Blanking: digit `idx` (1..3) blanked iff `blank_lz`=1 and `disp` nibbles `idx`..3 all zero. Value 0 shows a single "0" on digit 0.
- Load: `load`=1 → `pend` ← `value`, `pend_v` ← 1. Second load before commit overwrites `pend` (last wins).
- Commit: on `tick` with `idx`==3 (frame wrap) and `pend_v`=1 → `disp` ← `pend`, `pend_v` ← 0, `commit` ← 1 next cycle only. Frame wrap with `pend_v`=0: no change, no pulse.
- Simultaneous `load` and commit edge: `disp` takes old `pend`; `pend` takes new `value`; `pend_v` stays 1 (committed next frame).
- `x` remains valid while blanked (decoder output ignored via `anode_L`).

## Timing
- Reset (`rst`=1 at edge): `cnt`=0, `idx`=0, `disp`=0, `pend`=0, `pend_v`=0, `commit`=0 → `x`=4'h0, `anode_L`=4'b1110. Reset wins over `load` in same cycle. Reset mid-frame discards pending value, restarts at digit 0.
- Each digit lit exactly REFRESH_DIV cycles; frame = 4×REFRESH_DIV cycles.
- After reset, first `idx` change at edge REFRESH_DIV (counting the first post-reset edge as 1).
- Load-to-display latency: up to 4×REFRESH_DIV cycles; new `disp` visible in the same cycle `commit`=1; first digit shown is digit 0.
- `commit` high exactly one cycle per committed value.

## Structure
- Package `seg_pkg`: `NDIG`=4, `ANODE_OFF`=4'b1111, digit index type (2-bit), function one-hot-low anode from index.
- Sub-module `tick_gen` (parameters REFRESH_DIV, CNT_W; ports `clk`, `rst`, `tick`): the prescaler. Remaining logic in `seg_scan`.
- Top-level wiring: `seg_scan.x` → segment decoder input; `seg_scan.anode_L` → board anodes directly.

## Test plan
Bench runs with REFRESH_DIV=4, CNT_W=3.
- Reset: hold `rst` 2 cycles → `x`=0, `anode_L`=4'b1110, `commit`=0; `anode_L` steps 1110→1101→1011→0111→1110 every 4 cycles.
- Load 16'h1A2F mid-frame (`idx`=1) → no `disp` change until frame wrap; `commit` pulses once; then `x` sequence F,2,A,1 with 4 cycles each.
- Double load 16'h1111 then 16'h2222 in same frame → single `commit`; displayed 2,2,2,2.
- `load` 16'h00B0 on commit cycle while pending 16'hC0DE → `disp`=C0DE that frame, B0 committed next frame with second `commit` pulse.
- `blank_lz`=1, `disp`=16'h0070 → digits 0,1 lit (x=0, 7), digits 2,3 `anode_L`=4'b1111; `disp`=0 → only digit 0 lit.
- Assert `rst` with `pend_v`=1 at `idx`=2 → `idx`=0, `disp`=0, no `commit` at next wrap.
